scoot_bot: RTL and testbench
============================

# scoot_bot

Grid-foraging controller for a single "scoot bot" agent in the evolverilog arena. Each clock it reads four adjacent-cell item sensors and drives exactly one one-hot move request (up/right/down/left) to the arena simulator. An item in any adjacent cell is chased with fixed priority; otherwise the bot wanders in straight runs, turning at fixed intervals.

## Interface
- `STEP_CYCLES`, default 8: clocks per wander step.
- `RUN_LEN`, default 3: wander steps per heading before turning (≥1).
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `mUp` out 1: move request +y.
- `mRight` out 1: move request +x.
- `mDown` out 1: move request −y.
- `mLeft` out 1: move request −x.
- `lUp` in 1: item present in cell +y.
- `lRight` in 1: item present in cell +x.
- `lDown` in 1: item present in cell −y.
- `lLeft` in 1: item present in cell −x.
- Port order: `mUp`, `mRight`, `mDown`, `mLeft`, `lUp`, `lRight`, `lDown`, `lLeft`, `clk`, `reset`.

## Operation
- **State:**
  - `heading` (2-bit: UP=0, RIGHT=1, DOWN=2, LEFT=3).
  - `cyc_cnt` (0..STEP_CYCLES−1).
  - `step_cnt` (0..RUN_LEN−1).
  - four registered move outputs.
- **Reset:** all move outputs 0, `heading`=UP, counters 0; applies immediately on `reset` assertion, even mid-run.
- **Chase mode:** active when any of `lUp|lRight|lDown|lLeft`=1 at an edge.
  - Target direction by priority Up > Right > Down > Left.
  - Target is driven one-hot and loaded into `heading`; both counters cleared.
- **Wander mode:** active when all sensors are 0.
  - Output is one-hot of `heading`.
  - `cyc_cnt` increments; on wrap from STEP_CYCLES−1 to 0, `step_cnt` increments.
  - When `step_cnt`=RUN_LEN−1 and `cyc_cnt` wraps, `heading` turns clockwise (UP→RIGHT→DOWN→LEFT→UP) and `step_cnt` returns to 0.
- Outside reset, exactly one move output is 1 at all times; never two, never zero.
- Sensors are treated as synchronous to `clk`. No synchronizers.
- Counter widths: `$clog2` of the parameter, minimum 1 bit. Comparisons are exact; no counter overflow is possible.

## Timing
- **Latency:** 1 cycle. Outputs reflect sensor values sampled at rising edge N, valid after edge N.
- **Reset release:** the first edge after `reset` deasserts drives `mUp`=1, provided sensors are 0.
- **Turn timing:** a wander turn takes effect on the same edge as the terminal count. The new direction is visible RUN_LEN·STEP_CYCLES edges after the previous heading load.
- **Chase/wander on the same edge:** chase wins; counters clear and no turn occurs.
- **Sensor drop:** when sensors fall to 0, wander resumes from the chased direction with counters at 0.
- No handshake. The arena samples outputs at arbitrary times ≥1 cycle after changing sensors.

## Configuration
- `SCOOT_BOT_LFSR_TURN_EN`
  - **Defined:** an 8-bit Fibonacci LFSR steers wander turns.
    - Polynomial x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset, advancing every clock.
    - At each wander turn: `lfsr[0]`=1 turns clockwise (heading+1); `lfsr[0]`=0 turns counter-clockwise (heading+3, mod 4).
  - **Undefined:** always clockwise; no LFSR logic is present.
- Chase behaviour is identical in both builds.

## Structure
- **Package `scoot_bot_pkg`:**
  - `dir_t` enum (UP, RIGHT, DOWN, LEFT).
  - Function `dir_onehot(dir_t)` returning {up, right, down, left}.
  - Function `sense_priority` returning the chase `dir_t`.
  - Constant `LFSR_SEED`=8'hA5.
- **Sub-module `scoot_bot_lfsr`:** the 8-bit LFSR with `clk`, `reset`, `q[7:0]`; instantiated only under the macro.
- Top holds the counters, heading register and output register.

## Test plan
- **Reset and idle:** assert `reset`, sensors 0 → all outputs 0. Release → `mUp`=1 on the first edge and for 24 edges, then `mRight`=1.
- **Wander cycle:** sensors 0 for 96 edges after reset (non-LFSR build) → Up, Right, Down, Left in 24-cycle runs, then Up again.
- **Chase priority:** `lDown`=1 and `lLeft`=1 → `mDown`=1 next edge. Add `lUp`=1 → `mUp`=1 next edge.
- **Chase-to-wander:** `lRight`=1 for 3 cycles, then 0 → `mRight` held for 24 cycles after the drop, then `mDown`.
- **Async reset mid-run:** assert `reset` between edges during `mLeft` → outputs 0 immediately. After release, `heading`=UP.
- **LFSR build:** the first 4 turn directions after reset match the LFSR `q[0]` sequence from seed 8'hA5. One-hot holds every cycle over 1000 random-sensor cycles.

Source files
------------

// File: rtl/scoot_bot_pkg.sv
// +------------------------------------------------------------------+
// | scoot_bot_pkg : shared types and helpers for the scoot_bot agent |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package scoot_bot_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Returns {up, right, down, left}.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    oh = 4'b0000;
    case (d)
      UP:      oh = 4'b1000;
      RIGHT:   oh = 4'b0100;
      DOWN:    oh = 4'b0010;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

  // Sensor vector is {up, right, down, left}; caller guarantees at least one bit set.
  function automatic dir_t sense_priority(input logic [3:0] s);
    dir_t d;
    if (s[3])      d = UP;
    else if (s[2]) d = RIGHT;
    else if (s[1]) d = DOWN;
    else           d = LEFT;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scoot_bot_lfsr.sv
// +------------------------------------------------------------------+
// | scoot_bot_lfsr : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1         |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module scoot_bot_lfsr
  import scoot_bot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       w_fb;

  assign w_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_d = {lfsr_q[6:0], w_fb};
  assign q      = lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scoot_bot.sv
// +------------------------------------------------------------------+
// | scoot_bot : grid-foraging controller (chase items, else wander)  |
// | Option macro SCOOT_BOT_LFSR_TURN_EN selects LFSR-steered turns.  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module scoot_bot
  import scoot_bot_pkg::*;
#(
  parameter int STEP_CYCLES = 8,
  parameter int RUN_LEN     = 3
) (
  output logic mUp,
  output logic mRight,
  output logic mDown,
  output logic mLeft,
  input  logic lUp,
  input  logic lRight,
  input  logic lDown,
  input  logic lLeft,
  input  logic clk,
  input  logic reset
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [CW-1:0] c_CYC_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] c_STEP_LAST = SW'(RUN_LEN - 1);

  dir_t          heading_q, heading_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0]    move_q, move_d;
  logic [3:0]    w_sense;
  dir_t          w_turn;

  assign w_sense = {lUp, lRight, lDown, lLeft};

`ifdef SCOOT_BOT_LFSR_TURN_EN
  logic [7:0] w_lfsr;

  scoot_bot_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  assign w_turn = w_lfsr[0] ? dir_t'(heading_q + 2'd1) : dir_t'(heading_q + 2'd3);
`else
  assign w_turn = dir_t'(heading_q + 2'd1);
`endif

  // Chase overrides any wander bookkeeping, including a turn due on the same edge.
  always_comb begin
    heading_d = heading_q;
    cyc_d     = cyc_q + 1'b1;
    step_d    = step_q;
    if (|w_sense) begin
      heading_d = sense_priority(w_sense);
      cyc_d     = '0;
      step_d    = '0;
    end else if (cyc_q == c_CYC_LAST) begin
      cyc_d = '0;
      if (step_q == c_STEP_LAST) begin
        step_d    = '0;
        heading_d = w_turn;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
    move_d = dir_onehot(heading_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      heading_q <= UP;
      cyc_q     <= '0;
      step_q    <= '0;
      move_q    <= 4'b0000;
    end else begin
      heading_q <= heading_d;
      cyc_q     <= cyc_d;
      step_q    <= step_d;
      move_q    <= move_d;
    end
  end

  assign {mUp, mRight, mDown, mLeft} = move_q;

endmodule

`default_nettype wire

// File: tb/tb_scoot_bot.sv
// +------------------------------------------------------------------+
// | tb_scoot_bot : directed self-checking bench for scoot_bot        |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_scoot_bot;

  logic clk;
  logic reset;
  logic lUp, lRight, lDown, lLeft;
  logic mUp, mRight, mDown, mLeft;

  int checks;
  int errors;

  localparam logic [3:0] c_NONE  = 4'b0000;
  localparam logic [3:0] c_UP    = 4'b1000;
  localparam logic [3:0] c_RIGHT = 4'b0100;
  localparam logic [3:0] c_DOWN  = 4'b0010;
  localparam logic [3:0] c_LEFT  = 4'b0001;

  scoot_bot #(
    .STEP_CYCLES (8),
    .RUN_LEN     (3)
  ) dut (
    .mUp    (mUp),
    .mRight (mRight),
    .mDown  (mDown),
    .mLeft  (mLeft),
    .lUp    (lUp),
    .lRight (lRight),
    .lDown  (lDown),
    .lLeft  (lLeft),
    .clk    (clk),
    .reset  (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] moves();
    return {mUp, mRight, mDown, mLeft};
  endfunction

  // Advance n rising edges, then settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s);
    @(negedge clk);
    {lUp, lRight, lDown, lLeft} = s;
  endtask

  function automatic logic [3:0] prio(input logic [3:0] s);
    if (s[3]) return c_UP;
    if (s[2]) return c_RIGHT;
    if (s[1]) return c_DOWN;
    return c_LEFT;
  endfunction

  initial begin
    logic [3:0] s;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    {lUp, lRight, lDown, lLeft} = 4'b0000;

    // Reset state
    tick(3);
    chk("reset_outputs", moves(), c_NONE);

    // Release and idle wander: 24-edge runs, turn on the terminal edge
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    chk("release_first_up", moves(), c_UP);
    tick(22);
    chk("wander_up_edge23", moves(), c_UP);
    tick(1);
`ifndef SCOOT_BOT_LFSR_TURN_EN
    chk("wander_right_edge24", moves(), c_RIGHT);
    tick(24);
    chk("wander_down_edge48", moves(), c_DOWN);
    tick(24);
    chk("wander_left_edge72", moves(), c_LEFT);
    tick(23);
    chk("wander_left_edge95", moves(), c_LEFT);
    tick(1);
    chk("wander_up_edge96", moves(), c_UP);
`else
    chk("lfsr_turn_onehot", 32'($onehot(moves())), 32'd1);
`endif

    // Chase priority
    drive(4'b0011);
    tick(1);
    chk("chase_down_over_left", moves(), c_DOWN);
    drive(4'b1011);
    tick(1);
    chk("chase_up_over_all", moves(), c_UP);
    drive(4'b0110);
    tick(1);
    chk("chase_right_over_down", moves(), c_RIGHT);

    // Chase-to-wander: heading loaded on the last chase edge
    drive(4'b0100);
    tick(3);
    chk("chase_right_held", moves(), c_RIGHT);
    drive(4'b0000);
    tick(23);
    chk("drop_right_edge23", moves(), c_RIGHT);
    tick(1);
`ifndef SCOOT_BOT_LFSR_TURN_EN
    chk("drop_turn_down", moves(), c_DOWN);
    tick(24);
    chk("run_to_left", moves(), c_LEFT);
`endif

    // Async reset between edges takes effect without a clock
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_clear", moves(), c_NONE);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    chk("post_reset_up", moves(), c_UP);
    tick(22);
    chk("post_reset_up_edge23", moves(), c_UP);

    // Chase on the terminal-count edge wins; counters restart from the chase
    drive(4'b0001);
    tick(1);
    chk("chase_wins_terminal", moves(), c_LEFT);
    drive(4'b0000);
    tick(23);
    chk("left_run_edge23", moves(), c_LEFT);
    tick(1);
`ifndef SCOOT_BOT_LFSR_TURN_EN
    chk("left_turns_up", moves(), c_UP);
`endif

    // Random sensors: chase target exact, one-hot always
    for (int i = 0; i < 1000; i++) begin
      s = 4'($urandom_range(0, 15));
      if ((i % 4) == 0) s = 4'b0000;
      drive(s);
      tick(1);
      if (s != 4'b0000) chk("rand_chase", moves(), prio(s));
      chk("rand_onehot", 32'($onehot(moves())), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
